// File: rtl/symcounter_pkg.sv
// symcounter_pkg: shared types and constants for the symbol generator.
package symcounter_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } gen_state_t;

    localparam logic [31:0] DEFAULT_PERIOD = 32'd100000000;
    localparam logic [15:0] LFSR_MASK      = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_MASK : 16'h0000);
    endfunction

endpackage

// File: rtl/sym_lfsr.sv
// sym_lfsr: 16-bit right-shifting Galois LFSR that advances when en_i is high.
module sym_lfsr
    import symcounter_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        Clk100M,
    input  logic        Reset,
    input  logic        en_i,
    output logic [15:0] state_o
);

    logic [15:0] lfsr_q, lfsr_d;

    always_comb lfsr_d = en_i ? lfsr_step(lfsr_q) : lfsr_q;

    always_ff @(posedge Clk100M) begin
        if (Reset) lfsr_q <= SEED;
        else       lfsr_q <= lfsr_d;
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/symbol_generator.sv
// symbol_generator: periodic pseudo-random symbols on a valid/ready port,
// dropping and counting new symbols while an untaken one is held.
module symbol_generator
    import symcounter_pkg::*;
#(
    parameter int          SYM_WIDTH   = 4,
    parameter int          NUM_SYMBOLS = 10,
    parameter int          MIN_PERIOD  = 1000,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                 Clk100M,
    input  logic                 Reset,
    input  logic                 Enable,
    input  logic                 newLevel,
    input  logic [31:0]          symGenMax,
    input  logic                 symReady,
    output logic                 symValid,
    output logic [SYM_WIDTH-1:0] symbol,
    output logic                 symDropped,
    output logic [7:0]           dropCount
);

    localparam logic [31:0] MIN_P = 32'(MIN_PERIOD);
    localparam logic [4:0]  NUM_W = 5'(NUM_SYMBOLS);

    gen_state_t           state_q, state_d;
    logic [31:0]          period_q, period_d;
    logic [31:0]          counter_q, counter_d;
    logic                 valid_q, valid_d;
    logic [SYM_WIDTH-1:0] symbol_q, symbol_d;
    logic                 drop_q, drop_d;
    logic [7:0]           drop_cnt_q, drop_cnt_d;

    logic [15:0] lfsr;
    logic        lfsr_unused;
    logic        run, tick, load, drop;
    logic [31:0] clamped;
    logic [4:0]  raw;
    logic [3:0]  mapped;

    sym_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .Clk100M (Clk100M),
        .Reset   (Reset),
        .en_i    (run),
        .state_o (lfsr)
    );

    assign lfsr_unused = ^lfsr[15:4];

    // newLevel owns the counter on its cycle, so it suppresses a coincident tick
    always_comb begin
        run        = state_q == RUN;
        tick       = run && counter_q == period_q - 32'd1 && !newLevel;
        load       = tick && (!valid_q || symReady);
        drop       = tick && valid_q && !symReady;
        raw        = {1'b0, lfsr[3:0]};
        mapped     = raw < NUM_W ? raw[3:0] : 4'(raw - NUM_W);
        clamped    = (symGenMax[31] || symGenMax < MIN_P) ? MIN_P : symGenMax;
        state_d    = Enable ? RUN : IDLE;
        period_d   = newLevel ? clamped : period_q;
        counter_d  = (newLevel || tick) ? 32'd0 : run ? counter_q + 32'd1 : counter_q;
        valid_d    = tick ? 1'b1 : (valid_q && symReady) ? 1'b0 : valid_q;
        symbol_d   = load ? SYM_WIDTH'(mapped) : symbol_q;
        drop_d     = drop;
        drop_cnt_d = (drop && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
    end

    always_ff @(posedge Clk100M) begin
        if (Reset) begin
            state_q    <= IDLE;
            period_q   <= DEFAULT_PERIOD;
            counter_q  <= '0;
            valid_q    <= 1'b0;
            symbol_q   <= '0;
            drop_q     <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            period_q   <= period_d;
            counter_q  <= counter_d;
            valid_q    <= valid_d;
            symbol_q   <= symbol_d;
            drop_q     <= drop_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign symValid   = valid_q;
    assign symbol     = symbol_q;
    assign symDropped = drop_q;
    assign dropCount  = drop_cnt_q;

endmodule

// File: tb/tb_symbol_generator.sv
// tb_symbol_generator: directed stimulus with a cycle model of the generator
// checked every cycle, plus literal timing and drop-count expectations.
module tb_symbol_generator;

    localparam int MINP = 16;
    localparam int NSYM = 10;

    logic        Clk100M = 1'b0;
    logic        Reset = 1'b1;
    logic        Enable = 1'b0;
    logic        newLevel = 1'b0;
    logic [31:0] symGenMax = '0;
    logic        symReady = 1'b0;
    logic        symValid;
    logic [3:0]  symbol;
    logic        symDropped;
    logic [7:0]  dropCount;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 Clk100M = ~Clk100M;

    symbol_generator #(
        .SYM_WIDTH   (4),
        .NUM_SYMBOLS (NSYM),
        .MIN_PERIOD  (MINP),
        .LFSR_SEED   (16'hACE1)
    ) dut (
        .Clk100M    (Clk100M),
        .Reset      (Reset),
        .Enable     (Enable),
        .newLevel   (newLevel),
        .symGenMax  (symGenMax),
        .symReady   (symReady),
        .symValid   (symValid),
        .symbol     (symbol),
        .symDropped (symDropped),
        .dropCount  (dropCount)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: elapsed RUN cycles since the last reload/tick; a symbol is due when
    // the elapsed count would complete a full period.
    bit          m_ok = 0;
    bit          m_run;
    longint      m_elapsed, m_period;
    logic [15:0] m_lfsr;
    logic        m_valid, m_drop;
    int          m_sym, m_dc;

    function automatic int clamp_period(input logic [31:0] g);
        return (g[31] || g < MINP) ? MINP : int'(g);
    endfunction

    always @(posedge Clk100M) begin
        bit due;
        cyc++;
        if (Reset) begin
            m_ok = 1; m_run = 0; m_elapsed = 0; m_period = 100000000;
            m_lfsr = 16'hACE1; m_valid = 0; m_sym = 0; m_drop = 0; m_dc = 0;
        end else begin
            due = m_run && (m_elapsed + 1 == m_period) && !newLevel;
            m_drop = due && m_valid && !symReady;
            if (m_drop) m_dc = (m_dc < 255) ? m_dc + 1 : 255;
            else if (due) begin m_sym = int'(m_lfsr[3:0]) % NSYM; m_valid = 1; end
            else if (m_valid && symReady) m_valid = 0;
            if (m_run) m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
            if (newLevel || due) m_elapsed = 0;
            else if (m_run) m_elapsed++;
            if (newLevel) m_period = clamp_period(symGenMax);
            m_run = Enable;
        end
    end

    always @(negedge Clk100M) begin
        if (m_ok) begin
            check("symValid", symValid, m_valid);
            check("symbol", symbol, m_sym);
            check("symDropped", symDropped, m_drop);
            check("dropCount", dropCount, m_dc);
            if (symValid) check("symbol_range", symbol < NSYM, 1);
        end
    end

    task automatic tickn(input int n);
        repeat (n) @(negedge Clk100M);
    endtask

    task automatic wait_sig(input bit use_drop, input int budget, input int t0, input int exp, input string name);
        int k = 0;
        do begin
            @(negedge Clk100M);
            k++;
        end while (!(use_drop ? symDropped : symValid) && k < budget);
        check(name, cyc - t0, exp);
    endtask

    task automatic reset_literals(input string tag);
        check({tag, "_valid"}, symValid, 0);
        check({tag, "_symbol"}, symbol, 0);
        check({tag, "_dropped"}, symDropped, 0);
        check({tag, "_dropcount"}, dropCount, 0);
    endtask

    initial begin
        int t0, t1, nd;
        int held;
        tickn(3);
        reset_literals("reset");
        Reset = 0; symReady = 1; newLevel = 1; symGenMax = 1000;
        tickn(1);
        newLevel = 0; Enable = 1; t0 = cyc;
        wait_sig(0, 1010, t0, 1001, "first_tick_latency");
        tickn(1);
        check("valid_one_cycle", symValid, 0);
        t0 = cyc - 1;
        wait_sig(0, 1010, t0, 1000, "steady_period");
        tickn(1);
        newLevel = 1; symGenMax = 5; t0 = cyc;
        tickn(1);
        newLevel = 0;
        wait_sig(0, 40, t0, MINP + 1, "clamp_small");
        tickn(1);
        newLevel = 1; symGenMax = 32'hFFFF_FF00; t0 = cyc;
        tickn(1);
        newLevel = 0;
        wait_sig(0, 40, t0, MINP + 1, "clamp_wrapped");
        tickn(1);
        symReady = 0; newLevel = 1; symGenMax = 16; t0 = cyc;
        tickn(1);
        newLevel = 0;
        wait_sig(0, 40, t0, 17, "drop_first_tick");
        held = m_sym;
        nd = 0;
        repeat (33) begin
            @(negedge Clk100M);
            if (symDropped) nd++;
        end
        check("drop_pulses", nd, 2);
        check("dropcount_two", dropCount, 2);
        check("held_valid", symValid, 1);
        check("held_symbol", symbol, held);
        tickn(300 * 16);
        check("dropcount_saturated", dropCount, 255);
        newLevel = 1; symGenMax = 1000; t0 = cyc;
        tickn(1);
        newLevel = 0;
        tickn(399);
        Enable = 0;
        tickn(500);
        Enable = 1; t1 = cyc;
        wait_sig(1, 620, t1, 601, "pause_resume_tick");
        check("pause_held_valid", symValid, 1);
        check("pause_held_symbol", symbol, held);
        check("pause_dropcount", dropCount, 255);
        symReady = 1; newLevel = 1; symGenMax = 16; t0 = cyc;
        tickn(1);
        newLevel = 0;
        tickn(15);
        newLevel = 1; t1 = cyc;
        tickn(1);
        newLevel = 0;
        wait_sig(0, 40, t1, 17, "newlevel_at_terminal");
        symReady = 0;
        tickn(15);
        symReady = 1;
        tickn(1);
        check("coincide_valid", symValid, 1);
        check("coincide_nodrop", symDropped, 0);
        check("coincide_dropcount", dropCount, 255);
        Reset = 1;
        tickn(1);
        reset_literals("midrun_reset");
        Reset = 0;
        tickn(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog actual=timeout expected=finish (cycle %0d)", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
